// File: rtl/pdp_fp17_win_sum.sv
// Window-sum sequencer for the PDP pooling datapath: folds each window of N
// 4-lane fp17 vectors into one sum by round-tripping through an external adder.
module pdp_fp17_win_sum #(
    parameter int CNT_W = 4
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic [CNT_W-1:0] cfg_win_size,
    input  logic             in_pvld,
    output logic             in_prdy,
    input  logic [67:0]      in_pd,
    output logic [67:0]      add_in_a,
    output logic [67:0]      add_in_b,
    output logic             add_in_pvld,
    input  logic             add_in_prdy,
    input  logic [67:0]      add_out_dp,
    input  logic             add_out_pvld,
    output logic             add_out_prdy,
    output logic             out_pvld,
    input  logic             out_prdy,
    output logic [67:0]      out_pd
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t           state_r;
    logic [67:0]      acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] win_q_r;
    logic [CNT_W-1:0] cnt_inc_s;

    assign cnt_inc_s = cnt_r + CNT_W'(1);

    // Window sequencing: load first vector, then one adder round-trip per element.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state_r <= LOAD;
            acc_r   <= 68'd0;
            cnt_r   <= {CNT_W{1'b0}};
            win_q_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                LOAD: begin
                    if (in_pvld) begin
                        acc_r   <= in_pd;
                        win_q_r <= cfg_win_size;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= (cfg_win_size == {CNT_W{1'b0}}) ? OUT : ISSUE;
                    end
                end
                ISSUE: begin
                    if (in_pvld && add_in_prdy) begin
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    // cnt stops at win_q, so it never wraps even for the largest window
                    if (add_out_pvld) begin
                        acc_r   <= add_out_dp;
                        cnt_r   <= cnt_inc_s;
                        state_r <= (cnt_inc_s == win_q_r) ? OUT : ISSUE;
                    end
                end
                OUT: begin
                    if (out_prdy) begin
                        state_r <= LOAD;
                    end
                end
                default: begin
                    state_r <= LOAD;
                end
            endcase
        end
    end

    // Handshake decode from the state register; everything is held low during reset.
    always_comb begin
        in_prdy      = 1'b0;
        add_in_pvld  = 1'b0;
        add_out_prdy = 1'b0;
        out_pvld     = 1'b0;
        if (nvdla_core_rst) begin
            in_prdy = 1'b0;
        end else begin
            case (state_r)
                LOAD: begin
                    in_prdy = 1'b1;
                end
                ISSUE: begin
                    add_in_pvld = in_pvld;
                    in_prdy     = add_in_prdy;
                end
                WAIT: begin
                    add_out_prdy = 1'b1;
                end
                OUT: begin
                    out_pvld = 1'b1;
                end
                default: begin
                    in_prdy = 1'b0;
                end
            endcase
        end
    end

    assign add_in_a = acc_r;
    assign add_in_b = in_pd;
    assign out_pd   = acc_r;

endmodule

// File: tb/tb_pdp_fp17_win_sum.sv
// Scoreboard bench for pdp_fp17_win_sum with a behavioural 4-lane fp17 adder.
module tb_pdp_fp17_win_sum;

    localparam int CNT_W = 4;
    localparam int L     = 2;

    localparam logic [16:0] F_0P5 = 17'h07800;
    localparam logic [16:0] F_1   = 17'h07C00;
    localparam logic [16:0] F_2   = 17'h08000;
    localparam logic [16:0] F_3   = 17'h08200;
    localparam logic [16:0] F_4   = 17'h08400;
    localparam logic [16:0] F_6   = 17'h08600;
    localparam logic [16:0] F_8   = 17'h08800;
    localparam logic [16:0] F_10  = 17'h08900;
    localparam logic [16:0] F_M1  = 17'h17C00;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] cfg_win_size;
    logic             in_pvld, in_prdy;
    logic [67:0]      in_pd;
    logic [67:0]      add_in_a, add_in_b;
    logic             add_in_pvld, add_in_prdy;
    logic [67:0]      add_out_dp;
    logic             add_out_pvld, add_out_prdy;
    logic             out_pvld, out_prdy;
    logic [67:0]      out_pd;

    pdp_fp17_win_sum #(.CNT_W(CNT_W)) dut (
        .nvdla_core_clk(clk),
        .nvdla_core_rst(rst),
        .cfg_win_size(cfg_win_size),
        .in_pvld(in_pvld),
        .in_prdy(in_prdy),
        .in_pd(in_pd),
        .add_in_a(add_in_a),
        .add_in_b(add_in_b),
        .add_in_pvld(add_in_pvld),
        .add_in_prdy(add_in_prdy),
        .add_out_dp(add_out_dp),
        .add_out_pvld(add_out_pvld),
        .add_out_prdy(add_out_prdy),
        .out_pvld(out_pvld),
        .out_prdy(out_prdy),
        .out_pd(out_pd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [67:0]      pd;
        logic [CNT_W-1:0] cfg;
    } src_t;

    src_t        src_q[$];
    logic [67:0] exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int in_stall = 0, add_stall = 0, out_stall = 0, lat_extra = 0;
    bit force_out_low = 1'b0, force_add_low = 1'b0;
    bit src_fire = 1'b0, aout_fire = 1'b0, pend = 1'b0, prev_ovld = 1'b0;
    int lat = 0, n_add = 0, cyc = 0;
    int in_fire_cyc = -1, out_rise_cyc = -1, run = 0, last_width = 0;
    logic [67:0] res;

    always @(posedge clk) cyc <= cyc + 1;

    // fp17: sign[16], exponent[15:10] bias 31, mantissa[9:0]; values used are exact.
    function automatic real fp_dec(input logic [16:0] x);
        real r;
        int  e;
        int  mi;
        if (x[15:0] == 16'd0) return 0.0;
        e  = int'(x[15:10]);
        mi = int'({1'b1, x[9:0]});
        r  = $itor(mi);
        while (e > 41) begin r = r * 2.0; e--; end
        while (e < 41) begin r = r / 2.0; e++; end
        return x[16] ? -r : r;
    endfunction

    function automatic logic [16:0] fp_enc(input real v);
        real        a;
        int         e;
        int         m;
        logic [5:0] eb;
        logic [9:0] mb;
        if (v == 0.0) return 17'd0;
        a = (v < 0.0) ? -v : v;
        e = 41;
        while (a >= 2048.0) begin a = a / 2.0; e++; end
        while (a < 1024.0) begin a = a * 2.0; e--; end
        m  = $rtoi(a);
        eb = e[5:0];
        mb = m[9:0];
        return {(v < 0.0), eb, mb};
    endfunction

    function automatic logic [67:0] vec_add(input logic [67:0] a, input logic [67:0] b);
        logic [67:0] s;
        for (int k = 0; k < 4; k++)
            s[17*k +: 17] = fp_enc(fp_dec(a[17*k +: 17]) + fp_dec(b[17*k +: 17]));
        return s;
    endfunction

    function automatic logic [67:0] splat(input logic [16:0] x);
        return {x, x, x, x};
    endfunction

    function automatic logic [67:0] rand_vec();
        logic [67:0] v;
        int          n;
        for (int k = 0; k < 4; k++) begin
            n = int'($urandom_range(0, 200)) - 100;
            v[17*k +: 17] = fp_enc($itor(n));
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_vec(input logic [67:0] pd, input logic [CNT_W-1:0] cfg);
        src_t s;
        s.pd  = pd;
        s.cfg = cfg;
        src_q.push_back(s);
    endtask

    task automatic sample();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i;
        i = 0;
        while ((exp_q.size() > 0 || src_q.size() > 0) && i < budget) begin
            sample();
            i++;
        end
        check_int({name, "_done_in_time"}, int'(i < budget), 1);
        repeat (3) sample();
    endtask

    // Source: holds each vector stable until accepted.
    initial begin
        in_pvld = 1'b0;
        in_pd = 68'd0;
        cfg_win_size = '0;
        forever begin
            @(posedge clk);
            #1;
            if (src_fire && src_q.size() > 0) begin
                src_q.delete(0);
                in_pvld = 1'b0;
            end
            if (rst) begin
                in_pvld = 1'b0;
            end else if (!in_pvld && src_q.size() > 0 && int'($urandom_range(0, 99)) >= in_stall) begin
                in_pvld      = 1'b1;
                in_pd        = src_q[0].pd;
                cfg_win_size = src_q[0].cfg;
            end
            #1;
            src_fire = in_pvld && in_prdy;
            if (src_fire) in_fire_cyc = cyc;
        end
    end

    // Adder model: one transaction in flight, latency L plus optional random delay.
    initial begin
        add_in_prdy  = 1'b0;
        add_out_pvld = 1'b0;
        add_out_dp   = 68'd0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                lat = 0;
                pend = 1'b0;
                add_out_pvld = 1'b0;
            end else begin
                if (aout_fire) add_out_pvld = 1'b0;
                if (pend) begin
                    pend = 1'b0;
                    lat  = L + int'($urandom_range(0, lat_extra));
                end
                if (lat > 0) begin
                    lat--;
                    if (lat == 0) begin
                        add_out_pvld = 1'b1;
                        add_out_dp   = res;
                    end
                end
            end
            add_in_prdy = !force_add_low && int'($urandom_range(0, 99)) >= add_stall;
            #1;
            aout_fire = add_out_pvld && add_out_prdy;
            if (!rst && add_in_pvld && add_in_prdy) begin
                res  = vec_add(add_in_a, add_in_b);
                pend = 1'b1;
                n_add++;
            end
        end
    end

    // Sink ready generator.
    initial begin
        out_prdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_prdy = !force_out_low && int'($urandom_range(0, 99)) >= out_stall;
        end
    end

    // Monitor: pops the scoreboard on every accepted window sum.
    initial begin
        forever begin
            sample();
            if (!rst) begin
                if (out_pvld && !prev_ovld) out_rise_cyc = cyc;
                if (out_pvld) run++;
                else if (run > 0) begin
                    last_width = run;
                    run = 0;
                end
                prev_ovld = out_pvld;
                if (out_pvld && out_prdy) begin
                    check_int("sb_expected_present", int'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) check("out_pd", out_pd, exp_q.pop_front());
                end
            end else begin
                prev_ovld = 1'b0;
                run = 0;
            end
        end
    end

    initial begin
        int          base;
        int          n;
        int          i;
        logic [67:0] v;
        logic [67:0] acc;

        rst = 1'b1;
        repeat (3) sample();
        check("rst_ctl", 68'({in_prdy, add_in_pvld, add_out_prdy, out_pvld}), 68'd0);
        check("rst_add_in_a", add_in_a, 68'd0);
        check("rst_out_pd", out_pd, 68'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_int("post_rst_in_prdy", int'(in_prdy), 1);

        // Window of 3, ideal sinks
        base = n_add;
        push_vec(splat(F_1), 4'd2);
        push_vec(splat(F_2), 4'd2);
        push_vec(splat(F_3), 4'd2);
        exp_q.push_back(splat(F_6));
        wait_idle("win3", 500);
        check_int("win3_adder_txns", n_add - base, 2);
        check_int("win3_pulse_width", last_width, 1);

        // Window of 1: bit-exact pass-through one cycle after acceptance
        base = n_add;
        v = {F_8, F_4, F_M1, F_0P5};
        push_vec(v, 4'd0);
        exp_q.push_back(v);
        wait_idle("win1", 500);
        check_int("win1_latency", out_rise_cyc - in_fire_cyc, 1);
        check_int("win1_adder_txns", n_add - base, 0);

        // Output backpressure, with a further window queued behind it
        force_out_low = 1'b1;
        push_vec(splat(F_2), 4'd1);
        push_vec(splat(F_2), 4'd1);
        exp_q.push_back(splat(F_4));
        push_vec(splat(F_1), 4'd0);
        exp_q.push_back(splat(F_1));
        i = 0;
        while (!out_pvld && i < 100) begin sample(); i++; end
        check_int("bp_out_reached", int'(out_pvld), 1);
        for (int k = 0; k < 5; k++) begin
            check("bp_out_pd_hold", out_pd, splat(F_4));
            check_int("bp_in_prdy_low", int'(in_prdy), 0);
            sample();
        end
        force_out_low = 1'b0;
        wait_idle("bp_out", 500);

        // Adder input backpressure in ISSUE
        base = n_add;
        force_add_low = 1'b1;
        push_vec(splat(F_1), 4'd1);
        push_vec(splat(F_3), 4'd1);
        exp_q.push_back(splat(F_4));
        i = 0;
        while (!add_in_pvld && i < 100) begin sample(); i++; end
        check_int("bp_add_issue_reached", int'(add_in_pvld), 1);
        for (int k = 0; k < 3; k++) begin
            check_int("bp_add_in_prdy_low", int'(in_prdy), 0);
            sample();
        end
        force_add_low = 1'b0;
        wait_idle("bp_add", 500);
        check_int("bp_add_txns", n_add - base, 1);

        // Config change mid-window, then a 1-vector window
        base = n_add;
        push_vec(splat(F_1), 4'd3);
        push_vec(splat(F_2), 4'd3);
        push_vec(splat(F_3), 4'd0);
        push_vec(splat(F_4), 4'd0);
        exp_q.push_back(splat(F_10));
        push_vec(splat(F_0P5), 4'd0);
        exp_q.push_back(splat(F_0P5));
        wait_idle("cfg_change", 800);
        check_int("cfg_change_txns", n_add - base, 3);

        // Reset in WAIT after 2 of 4 vectors
        base = n_add;
        for (int k = 0; k < 4; k++) push_vec(splat(F_1), 4'd3);
        i = 0;
        while (!add_out_prdy && i < 100) begin sample(); i++; end
        check_int("rst_mid_wait_reached", int'(add_out_prdy), 1);
        check_int("rst_mid_txns", n_add - base, 1);
        rst = 1'b1;
        src_q.delete();
        in_pvld = 1'b0;
        lat = 0;
        pend = 1'b0;
        add_out_pvld = 1'b0;
        #1;
        check("rst_mid_ctl", 68'({in_prdy, add_in_pvld, add_out_prdy, out_pvld}), 68'd0);
        check("rst_mid_add_in_a", add_in_a, 68'd0);
        check("rst_mid_out_pd", out_pd, 68'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        push_vec(splat(F_1), 4'd1);
        push_vec(splat(F_1), 4'd1);
        exp_q.push_back(splat(F_2));
        wait_idle("rst_fresh", 500);

        // Back-to-back random windows with stalls everywhere
        in_stall = 30;
        add_stall = 30;
        out_stall = 30;
        lat_extra = 3;
        for (int w = 0; w < 200; w++) begin
            n = int'($urandom_range(1, 16));
            acc = 68'd0;
            for (int j = 0; j < n; j++) begin
                v = rand_vec();
                push_vec(v, 4'(n - 1));
                acc = (j == 0) ? v : vec_add(acc, v);
            end
            exp_q.push_back(acc);
        end
        wait_idle("random", 60000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
